// File: rtl/uart_pkg.sv
// Shared types and constants for the uarttx arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_e;

  // Bit-clock cycles uarttx spends on one frame (start + 8 data + stop).
  localparam int UART_FRAME_CYCLES = 10;
  // Two handshake cycles plus the frame itself.
  localparam int MIN_BYTE_PERIOD = 2 + UART_FRAME_CYCLES;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority picker: first asserted valid at or above ptr, wrapping at N.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          found
);

  logic [PW-1:0] cand_s;
  logic          hit_s;

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    cand_s = '0;
    hit_s  = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand_s = PW'((int'(ptr) + k) % N);
      hit_s  = valid[cand_s] & ~found;
      idx    = hit_s ? cand_s : idx;
      found  = found | hit_s;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uarttx byte transmitter between N requesters with packet locking.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N            = 4,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic           clock115200hz,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ack,
  output logic [N-1:0]   grant,
  output logic           locked,
  output logic [7:0]     tx_data,
  output logic           tx_send,
  input  logic           tx_ready
);

  localparam int PW = ptr_width(N);
  localparam int CW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  // Counter value on the edge that completes the LOCK_TIMEOUT-th idle cycle.
  localparam logic [CW-1:0] TO_LAST  = CW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
  localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);

  function automatic logic [N-1:0] onehot(input logic [PW-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
    return (i == LAST_IDX) ? '0 : i + PW'(1);
  endfunction

  arb_state_e    state_r, state_s;
  logic [PW-1:0] rr_ptr_r, rr_ptr_s;
  logic [PW-1:0] owner_r, owner_s;
  logic [N-1:0]  grant_r, grant_s;
  logic          locked_r, locked_s;
  logic [7:0]    tx_data_r, tx_data_s;
  logic          tx_send_r, tx_send_s;
  logic [N-1:0]  req_ack_r, req_ack_s;
  logic [CW-1:0] to_cnt_r, to_cnt_s;

  logic [PW-1:0] rr_idx_s;
  logic          rr_found_s;
  logic [PW-1:0] pick_idx_s;
  logic          pick_found_s;
  logic          to_active_s;
  logic          issue_s;

  uart_rr_pick #(.N(N), .PW(PW)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr_r),
    .idx   (rr_idx_s),
    .found (rr_found_s)
  );

  // Eligibility: the lock owner alone while locked, otherwise the rotating pick.
  always_comb begin
    pick_idx_s   = rr_idx_s;
    pick_found_s = rr_found_s;
    if (locked_r) begin
      pick_idx_s   = owner_r;
      pick_found_s = req_valid[owner_r];
    end else begin
      pick_idx_s   = rr_idx_s;
      pick_found_s = rr_found_s;
    end
    to_active_s = (LOCK_TIMEOUT != 0) && locked_r && !req_valid[owner_r];
  end

  // Next-state and next-output logic for the issue/wait controller.
  always_comb begin
    state_s   = state_r;
    rr_ptr_s  = rr_ptr_r;
    owner_s   = owner_r;
    grant_s   = grant_r;
    locked_s  = locked_r;
    tx_data_s = tx_data_r;
    tx_send_s = tx_send_r;
    req_ack_s = '0;
    to_cnt_s  = to_cnt_r;
    issue_s   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (tx_ready && pick_found_s) begin
          issue_s = 1'b1;
        end else if (to_active_s) begin
          if (to_cnt_r == TO_LAST) begin
            locked_s = 1'b0;
            grant_s  = '0;
            to_cnt_s = '0;
          end else begin
            to_cnt_s = to_cnt_r + CW'(1);
          end
        end else begin
          to_cnt_s = to_cnt_r;
        end
      end
      ST_ISSUE: begin
        // uarttx drops ready once it has taken the byte.
        if (!tx_ready) begin
          tx_send_s = 1'b0;
          state_s   = ST_WAIT_DONE;
        end else begin
          tx_send_s = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        // Frame finished: evaluate IDLE immediately so back-to-back bytes lose no cycle.
        if (tx_ready) begin
          state_s = ST_IDLE;
          if (!locked_r) begin
            grant_s = '0;
          end else begin
            grant_s = grant_r;
          end
          issue_s = pick_found_s;
        end else begin
          state_s = ST_WAIT_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (issue_s) begin
      tx_data_s = req_data[{pick_idx_s, 3'b000} +: 8];
      req_ack_s = onehot(pick_idx_s);
      grant_s   = onehot(pick_idx_s);
      owner_s   = pick_idx_s;
      tx_send_s = 1'b1;
      locked_s  = !req_last[pick_idx_s];
      rr_ptr_s  = next_ptr(pick_idx_s);
      to_cnt_s  = '0;
      state_s   = ST_ISSUE;
    end else begin
      req_ack_s = '0;
    end
  end

  // State and registered outputs, with synchronous reset.
  always_ff @(posedge clock115200hz) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      rr_ptr_r  <= '0;
      owner_r   <= '0;
      grant_r   <= '0;
      locked_r  <= 1'b0;
      tx_data_r <= 8'h00;
      tx_send_r <= 1'b0;
      req_ack_r <= '0;
      to_cnt_r  <= '0;
    end else begin
      state_r   <= state_s;
      rr_ptr_r  <= rr_ptr_s;
      owner_r   <= owner_s;
      grant_r   <= grant_s;
      locked_r  <= locked_s;
      tx_data_r <= tx_data_s;
      tx_send_r <= tx_send_s;
      req_ack_r <= req_ack_s;
      to_cnt_r  <= to_cnt_s;
    end
  end

  assign req_ack = req_ack_r;
  assign grant   = grant_r;
  assign locked  = locked_r;
  assign tx_data = tx_data_r;
  assign tx_send = tx_send_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a uarttx model and a packet-level reference.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N            = 4;
  localparam int LOCK_TIMEOUT = 64;
  localparam int PB           = 64;

  logic           clock115200hz = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   grant;
  logic           locked;
  logic [7:0]     tx_data;
  logic           tx_send;
  logic           tx_ready;

  always #5 clock115200hz = ~clock115200hz;

  uart_tx_arbiter #(.N(N), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
    .clock115200hz (clock115200hz),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ack       (req_ack),
    .grant         (grant),
    .locked        (locked),
    .tx_data       (tx_data),
    .tx_send       (tx_send),
    .tx_ready      (tx_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string note);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, note);
  endtask

  function automatic logic [N-1:0] oh(input int r);
    logic [N-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  // ---------------- uarttx model: ready low for 10 bits, samples tx_data live ----------------
  logic       u_ready = 1'b1;
  logic       u_busy = 1'b0;
  logic       u_hold = 1'b0;
  int         u_bit = 0;
  logic [7:0] u_shift = 8'h00;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;

  assign tx_ready = u_ready & ~u_hold;

  // Bit-serial frame: start, 8 data bits LSB first sampled from tx_data, stop.
  always @(posedge clock115200hz) begin
    rx_valid <= 1'b0;
    if (!u_busy) begin
      if (tx_send && u_ready) begin
        u_busy  <= 1'b1;
        u_ready <= 1'b0;
        u_bit   <= 1;
      end
    end else begin
      if (u_bit <= 8) begin
        u_shift[u_bit-1] <= tx_data[u_bit-1];
      end else if (u_bit == 10) begin
        u_busy   <= 1'b0;
        u_ready  <= 1'b1;
        rx_byte  <= u_shift;
        rx_valid <= 1'b1;
      end
      u_bit <= u_bit + 1;
    end
  end

  // ---------------- producers ----------------
  logic [8:0] pbuf [N][PB];
  int         phead [N];
  int         ptail [N];

  // Each requester presents its queue front; idle requesters drive random data.
  always @(negedge clock115200hz) begin
    for (int i = 0; i < N; i++) begin
      if (req_ack[i] && phead[i] != ptail[i]) phead[i] = phead[i] + 1;
      if (phead[i] != ptail[i]) begin
        req_valid[i]      = 1'b1;
        req_data[8*i +: 8] = pbuf[i][phead[i]][7:0];
        req_last[i]       = pbuf[i][phead[i]][8];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i]       = 1'($urandom);
      end
    end
  end

  task automatic clear_bufs();
    for (int i = 0; i < N; i++) begin
      phead[i] = 0;
      ptail[i] = 0;
    end
  endtask

  task automatic push_pkt(input int r, input int len, input logic [7:0] d, input bit rnd);
    for (int b = 0; b < len; b++) begin
      pbuf[r][ptail[r]] = {(b == len - 1), (rnd ? 8'($urandom) : d)};
      ptail[r] = ptail[r] + 1;
    end
  endtask

  // ---------------- reference model and scoreboard ----------------
  typedef struct packed {
    logic [3:0] req;
    logic       last;
  } ack_t;

  ack_t       exp_ack_q [$];
  logic [7:0] exp_byte_q [$];
  int         m_ptr = 0;
  int         m_owner = -1;

  // Plays out the loaded packets: owner keeps the link until its last byte
  // (or until it runs dry, which the lock timeout resolves), else round-robin.
  task automatic model_run();
    int mh [N];
    int j;
    bit more;
    logic [8:0] w;
    for (int i = 0; i < N; i++) mh[i] = phead[i];
    more = 1'b1;
    while (more) begin
      j = -1;
      if (m_owner >= 0 && mh[m_owner] != ptail[m_owner]) begin
        j = m_owner;
      end else begin
        m_owner = -1;
        for (int k = 0; k < N; k++) begin
          if (j < 0 && mh[(m_ptr + k) % N] != ptail[(m_ptr + k) % N]) j = (m_ptr + k) % N;
        end
      end
      if (j < 0) begin
        more = 1'b0;
      end else begin
        w = pbuf[j][mh[j]];
        mh[j] = mh[j] + 1;
        exp_ack_q.push_back('{req: 4'(j), last: w[8]});
        exp_byte_q.push_back(w[7:0]);
        m_ptr   = (j + 1) % N;
        m_owner = w[8] ? -1 : j;
      end
    end
  endtask

  int   cyc = 0;
  logic prev_send = 1'b0;
  logic prev_ready = 1'b1;
  bit   per_en = 1'b0;
  int   last_rise = -1;
  bit   abort = 1'b0;

  // Monitor: acks, handshake shape, send spacing and received frames.
  always @(negedge clock115200hz) begin
    ack_t e;
    cyc++;
    if (req_ack != '0) begin
      if (exp_ack_q.size() == 0) begin
        fail_now("ack_unexpected", $sformatf("got ack 0x%0h with nothing expected", req_ack));
      end else begin
        e = exp_ack_q.pop_front();
        chk("ack_req", 32'(req_ack), 32'(oh(int'(e.req))));
        chk("ack_grant", 32'(grant), 32'(oh(int'(e.req))));
        chk("ack_locked", 32'(locked), 32'(!e.last));
      end
    end
    if (prev_send && !prev_ready) chk("send_drop", 32'(tx_send), 32'd0);
    if (tx_send && !prev_send) begin
      if (per_en && last_rise >= 0) chk("send_period", 32'(cyc - last_rise), 32'(MIN_BYTE_PERIOD));
      last_rise = cyc;
    end
    if (rx_valid) begin
      if (abort) begin
        abort = 1'b0;
      end else if (exp_byte_q.size() == 0) begin
        fail_now("frame_unexpected", $sformatf("got byte 0x%0h with nothing expected", rx_byte));
      end else begin
        chk("frame_byte", 32'(rx_byte), 32'(exp_byte_q.pop_front()));
      end
    end
    prev_send  = tx_send;
    prev_ready = tx_ready;
  end

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_ack_q.size() != 0 || exp_byte_q.size() != 0 || u_busy) && n < budget) begin
      @(negedge clock115200hz);
      n++;
    end
    if (n >= budget) fail_now("drain", "expected traffic did not complete in time");
    repeat (3) @(negedge clock115200hz);
  endtask

  task automatic do_reset();
    @(negedge clock115200hz);
    reset = 1'b1;
    clear_bufs();
    m_ptr   = 0;
    m_owner = -1;
    repeat (2) @(negedge clock115200hz);
    reset = 1'b0;
  endtask

  task automatic wait_ack(input int r, input string name);
    int n;
    n = 0;
    while (!req_ack[r] && n < 100) begin
      @(negedge clock115200hz);
      n++;
    end
    if (n >= 100) fail_now(name, "no ack within 100 cycles");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int cnt;
    int mism;
    bit any;
    logic [7:0] held;
    logic [7:0] t2d [4];
    t2d[0] = 8'h10; t2d[1] = 8'h21; t2d[2] = 8'h32; t2d[3] = 8'h43;
    clear_bufs();
    repeat (3) @(negedge clock115200hz);

    // Reset values.
    chk("rst_ack", 32'(req_ack), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_tx_send", 32'(tx_send), 32'd0);

    // Single byte 0x41 from requester 0; held off while tx_ready=0.
    u_hold = 1'b1;
    reset  = 1'b0;
    push_pkt(0, 1, 8'h41, 1'b0);
    model_run();
    repeat (5) begin
      @(negedge clock115200hz);
      chk("no_ack_not_ready", 32'(req_ack), 32'd0);
    end
    u_hold = 1'b0;
    @(negedge clock115200hz);
    chk("first_ack", 32'(req_ack), 32'h1);
    chk("first_send", 32'(tx_send), 32'd1);
    wait_drain(100);
    chk("idle_grant", 32'(grant), 32'd0);
    chk("idle_locked", 32'(locked), 32'd0);

    // Locked 3-byte packet from requester 2 while requester 0 waits.
    clear_bufs();
    push_pkt(2, 3, 8'h00, 1'b1);
    push_pkt(0, 1, 8'h00, 1'b1);
    push_pkt(0, 1, 8'h00, 1'b1);
    model_run();
    per_en = 1'b1;
    last_rise = -1;
    wait_drain(200);
    per_en = 1'b0;

    // All four valid, two single-byte packets each, from a fresh pointer.
    do_reset();
    for (int r = 0; r < N; r++) begin
      push_pkt(r, 1, t2d[r], 1'b0);
      push_pkt(r, 1, t2d[r], 1'b0);
    end
    model_run();
    per_en = 1'b1;
    last_rise = -1;
    wait_drain(300);
    per_en = 1'b0;

    // Lock timeout: requester 1 leaves its packet open, requester 3 waits.
    do_reset();
    push_pkt(1, 1, 8'h00, 1'b1);
    pbuf[1][0][8] = 1'b0;
    push_pkt(3, 1, 8'h00, 1'b1);
    model_run();
    wait_ack(1, "to_first_ack");
    n = 0;
    while (tx_ready && n < 20) begin @(negedge clock115200hz); n++; end
    while (!tx_ready && n < 40) begin @(negedge clock115200hz); n++; end
    if (n >= 40) fail_now("to_frame", "frame did not complete");
    cnt = 0;
    n = 0;
    do begin
      @(negedge clock115200hz);
      if (locked) cnt++;
      n++;
    end while (locked && n < 4 * LOCK_TIMEOUT + 20);
    chk("timeout_len", 32'(cnt), 32'(LOCK_TIMEOUT));
    chk("timeout_grant", 32'(grant), 32'd0);
    chk("timeout_no_ack", 32'(req_ack), 32'd0);
    @(negedge clock115200hz);
    chk("ack_after_timeout", 32'(req_ack), 32'h8);
    wait_drain(100);

    // Reset during bit 4 of a frame; uarttx keeps running.
    clear_bufs();
    push_pkt(0, 1, 8'h5A, 1'b0);
    model_run();
    n = 0;
    while (!(u_busy && u_bit == 5) && n < 100) begin @(negedge clock115200hz); n++; end
    if (n >= 100) fail_now("midframe_wait", "frame never reached bit 4");
    reset = 1'b1;
    abort = 1'b1;
    exp_ack_q.delete();
    exp_byte_q.delete();
    clear_bufs();
    m_ptr   = 0;
    m_owner = -1;
    @(negedge clock115200hz);
    chk("mid_rst_ack", 32'(req_ack), 32'd0);
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_locked", 32'(locked), 32'd0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
    chk("mid_rst_tx_send", 32'(tx_send), 32'd0);
    reset = 1'b0;
    push_pkt(1, 1, 8'h3C, 1'b0);
    model_run();
    n = 0;
    while (!tx_ready && n < 40) begin
      chk("no_ack_while_busy", 32'(req_ack), 32'd0);
      @(negedge clock115200hz);
      n++;
    end
    chk("no_ack_ready_edge", 32'(req_ack), 32'd0);
    @(negedge clock115200hz);
    chk("ack_after_ready", 32'(req_ack), 32'h2);
    wait_drain(100);

    // tx_data holds while the idle requester's data wiggles every cycle.
    clear_bufs();
    push_pkt(0, 1, 8'hC3, 1'b0);
    model_run();
    wait_ack(0, "stab_ack");
    held = tx_data;
    chk("stab_ack_data", 32'(held), 32'hC3);
    mism = 0;
    repeat (13) begin
      @(negedge clock115200hz);
      if (tx_data !== held) mism++;
    end
    chk("stab_hold", 32'(mism), 32'd0);
    wait_drain(100);

    // Randomized packet mixes.
    for (int it = 0; it < 6; it++) begin
      clear_bufs();
      any = 1'b0;
      for (int r = 0; r < N; r++) begin
        if ($urandom_range(0, 2) != 0) begin
          for (int p = 0; p < int'($urandom_range(1, 3)); p++) push_pkt(r, int'($urandom_range(1, 4)), 8'h00, 1'b1);
          any = 1'b1;
        end
      end
      if (!any) push_pkt(int'($urandom_range(0, N - 1)), 2, 8'h00, 1'b1);
      model_run();
      per_en = 1'b1;
      last_rise = -1;
      wait_drain(1000);
      per_en = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
